// File: rtl/router_fifo_pkt.sv
// router_fifo_pkt: packet-aware output-channel FIFO that tracks packet boundaries from the header length field.
// Define ROUTER_FIFO_ERR_EN to build the sticky overflow/underflow flags; otherwise those ports are tied to 0.
module router_fifo_pkt #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    soft_reset,
  input  logic                    write_enb,
  input  logic                    read_enb,
  input  logic                    lfd_state,
  input  logic [DATA_WIDTH-1:0]   datain,
  output logic [DATA_WIDTH-1:0]   dataout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    pkt_busy,
  output logic                    pkt_done,
  output logic                    overflow,
  output logic                    underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = DATA_WIDTH - 1;
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   AF_C    = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0]   AE_C    = (AW+1)'(AE_LEVEL);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] PKT_ONE = CW'(1);

  logic [DATA_WIDTH:0]   mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic [CW-1:0]         pkt_cnt_q, pkt_cnt_d;
  logic [DATA_WIDTH-1:0] dataout_q, dataout_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  wr_acc, rd_acc;
  logic [DATA_WIDTH:0]   rd_entry;

  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign fifo_count   = count_q;
  assign pkt_busy     = (pkt_cnt_q != '0);
  assign pkt_done     = pkt_done_q;
  assign dataout      = dataout_q;

  // A write while full is dropped even if a read frees a slot in the same cycle.
  assign wr_acc   = write_enb && !full && !soft_reset;
  assign rd_acc   = read_enb && !empty && !soft_reset;
  assign rd_entry = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    pkt_cnt_d  = pkt_cnt_q;
    dataout_d  = dataout_q;
    pkt_done_d = 1'b0;
    if (soft_reset) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      pkt_cnt_d = '0;
      dataout_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d  = rd_ptr_q + PTR_ONE;
        dataout_d = rd_entry[DATA_WIDTH-1:0];
        // Header reload covers payload plus parity; also restarts a truncated packet.
        if (rd_entry[DATA_WIDTH]) begin
          pkt_cnt_d = {1'b0, rd_entry[DATA_WIDTH-1:2]} + PKT_ONE;
        end else if (pkt_cnt_q != '0) begin
          pkt_cnt_d  = pkt_cnt_q - PKT_ONE;
          pkt_done_d = (pkt_cnt_q == PKT_ONE);
        end
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      pkt_cnt_q  <= '0;
      dataout_q  <= '0;
      pkt_done_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      pkt_cnt_q  <= pkt_cnt_d;
      dataout_q  <= dataout_d;
      pkt_done_q <= pkt_done_d;
    end
  end

  // Storage is not reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= {lfd_state, datain};
  end

`ifdef ROUTER_FIFO_ERR_EN
  logic overflow_q, overflow_d, underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (soft_reset) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (write_enb && full) overflow_d = 1'b1;
      if (read_enb && empty) underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_router_fifo_pkt.sv
// tb_router_fifo_pkt: directed stimulus with a queue scoreboard; a negedge monitor checks dataout/pkt_done.
// Honours ROUTER_FIFO_ERR_EN for the expected overflow/underflow values.
module tb_router_fifo_pkt;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int CW = 5;
`ifdef ROUTER_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          soft_reset = 1'b0;
  logic          write_enb = 1'b0;
  logic          read_enb = 1'b0;
  logic          lfd_state = 1'b0;
  logic [DW-1:0] datain = '0;
  logic [DW-1:0] dataout;
  logic          full, empty, almost_full, almost_empty;
  logic [CW-1:0] fifo_count;
  logic          pkt_busy, pkt_done, overflow, underflow;

  router_fifo_pkt #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .soft_reset(soft_reset), .write_enb(write_enb),
    .read_enb(read_enb), .lfd_state(lfd_state), .datain(datain), .dataout(dataout),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .fifo_count(fifo_count), .pkt_busy(pkt_busy), .pkt_done(pkt_done),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            tgt;
    logic [DW-1:0] data;
    logic          done;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW:0]   mdl_q[$];
  int            m_pkt = 0;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;
  int            done_seen = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the expected read result the cycle the DUT presents it.
  always @(negedge clk) begin
    exp_t e;
    logic exp_done;
    exp_done = 1'b0;
    if (pkt_done === 1'b1) done_seen++;
    if (exp_q.size() > 0 && exp_q[0].tgt < cyc) begin
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL scoreboard: read result for cycle %0d never compared, now %0d", e.tgt, cyc);
    end
    if (exp_q.size() > 0 && exp_q[0].tgt == cyc) begin
      e = exp_q.pop_front();
      chk("dataout", 32'(dataout), 32'(e.data));
      exp_done = e.done;
    end
    chk("pkt_done", 32'(pkt_done), 32'(exp_done));
  end

  // Drive one cycle of inputs, update the reference queue, return 1 time unit after the edge.
  task automatic step(input bit we, input bit re, input bit lfd, input logic [DW-1:0] d,
                      input bit srst = 1'b0);
    logic [DW:0] ent;
    exp_t        x;
    bit          full_m, empty_m;
    write_enb  = we;
    read_enb   = re;
    lfd_state  = lfd;
    datain     = d;
    soft_reset = srst;
    if (srst) begin
      mdl_q.delete();
      m_pkt = 0;
    end else begin
      full_m  = (mdl_q.size() == DEPTH);
      empty_m = (mdl_q.size() == 0);
      if (re && !empty_m) begin
        ent    = mdl_q.pop_front();
        x.tgt  = cyc + 1;
        x.data = ent[DW-1:0];
        x.done = 1'b0;
        if (ent[DW]) begin
          m_pkt = int'(ent[DW-1:2]) + 1;
        end else if (m_pkt != 0) begin
          m_pkt--;
          x.done = (m_pkt == 0);
        end
        exp_q.push_back(x);
      end
      if (we && !full_m) mdl_q.push_back({lfd, d});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] par;
    logic [DW-1:0] d;

    // Reset values
    repeat (2) @(negedge clk);
    chk("rst_dataout", 32'(dataout), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_fifo_count", 32'(fifo_count), 0);
    chk("rst_pkt_busy", 32'(pkt_busy), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_underflow", 32'(underflow), 0);
    resetn = 1'b1;

    // 1: header 0x39 (len 14), 14 payload bytes, parity
    par = 8'h39;
    step(1, 0, 1, 8'h39);
    for (int i = 0; i < 14; i++) begin
      d = 8'(8'h10 + i * 8'h1D);
      par ^= d;
      step(1, 0, 0, d);
      if (i == 0) begin
        chk("cnt2_count", 32'(fifo_count), 2);
        chk("cnt2_almost_empty", 32'(almost_empty), 1);
      end
      if (i == 1) chk("cnt3_almost_empty", 32'(almost_empty), 0);
      if (i == 11) chk("cnt13_almost_full", 32'(almost_full), 0);
      if (i == 12) begin
        chk("cnt14_count", 32'(fifo_count), 14);
        chk("cnt14_almost_full", 32'(almost_full), 1);
        chk("cnt14_full", 32'(full), 0);
      end
    end
    chk("cnt15_full", 32'(full), 0);
    step(1, 0, 0, par);
    chk("cnt16_full", 32'(full), 1);
    chk("cnt16_count", 32'(fifo_count), 16);

    // 2: write while full is dropped
    step(1, 0, 0, 8'hAA);
    chk("ovf_count", 32'(fifo_count), 16);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_flag", 32'(overflow), 32'(ERR_EN));

    // 3: read 16 entries, one packet completes on the parity byte
    done_seen = 0;
    chk("pre_hdr_pkt_busy", 32'(pkt_busy), 0);
    step(0, 1, 0, 8'h00);
    chk("post_hdr_pkt_busy", 32'(pkt_busy), 1);
    for (int i = 0; i < 15; i++) step(0, 1, 0, 8'h00);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_pkt_busy", 32'(pkt_busy), 0);
    step(0, 1, 0, 8'h00);
    chk("pkt_done_pulses", 32'(done_seen), 1);
    chk("udf_flag", 32'(underflow), 32'(ERR_EN));
    chk("udf_dataout_hold", 32'(dataout), 32'(par));
    step(0, 0, 0, 8'h00);

    // 4: simultaneous read/write at count 5
    for (int i = 0; i < 5; i++) step(1, 0, 0, 8'(8'hC0 + i));
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 0, 8'(8'hD0 + i));
      chk("rw_count", 32'(fifo_count), 5);
    end
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'h00);
    chk("rw_drain_empty", 32'(empty), 1);

    // 5: soft reset mid-packet with a concurrent write
    step(1, 0, 1, 8'h14);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 8'(8'h60 + i));
    for (int i = 0; i < 3; i++) step(0, 1, 0, 8'h00);
    chk("pre_srst_pkt_busy", 32'(pkt_busy), 1);
    step(1, 0, 0, 8'h77, 1'b1);
    chk("srst_count", 32'(fifo_count), 0);
    chk("srst_empty", 32'(empty), 1);
    chk("srst_dataout", 32'(dataout), 0);
    chk("srst_pkt_busy", 32'(pkt_busy), 0);
    chk("srst_overflow", 32'(overflow), 0);
    chk("srst_underflow", 32'(underflow), 0);
    step(1, 0, 0, 8'h55);
    step(0, 1, 0, 8'h00);
    chk("post_srst_read", 32'(dataout), 32'h55);
    step(0, 0, 0, 8'h00);

    // 6: pointer wrap, zero-length packet, async reset mid-read
    for (int i = 0; i < 10; i++) step(1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 10; i++) step(0, 1, 0, 8'h00);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 8'(8'h30 + i * 3));
    chk("wrap_count", 32'(fifo_count), 12);
    for (int i = 0; i < 12; i++) step(0, 1, 0, 8'h00);
    chk("wrap_empty", 32'(empty), 1);
    step(1, 0, 1, 8'h01);
    step(1, 0, 0, 8'hEE);
    step(0, 1, 0, 8'h00);
    chk("zlen_hdr_pkt_done", 32'(pkt_done), 0);
    chk("zlen_hdr_pkt_busy", 32'(pkt_busy), 1);
    step(0, 1, 0, 8'h00);
    chk("zlen_par_pkt_done", 32'(pkt_done), 1);
    chk("zlen_par_dataout", 32'(dataout), 32'hEE);
    chk("zlen_par_pkt_busy", 32'(pkt_busy), 0);
    step(1, 0, 1, 8'h0C);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 8'(8'h41 + i));
    step(0, 1, 0, 8'h00);
    step(0, 1, 0, 8'h00);
    chk("pre_arst_pkt_busy", 32'(pkt_busy), 1);
    @(negedge clk);
    #2;
    resetn = 1'b0;
    #1;
    chk("arst_dataout", 32'(dataout), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_almost_empty", 32'(almost_empty), 1);
    chk("arst_fifo_count", 32'(fifo_count), 0);
    chk("arst_pkt_busy", 32'(pkt_busy), 0);
    chk("arst_pkt_done", 32'(pkt_done), 0);
    chk("arst_overflow", 32'(overflow), 0);
    chk("arst_underflow", 32'(underflow), 0);
    read_enb  = 1'b0;
    write_enb = 1'b0;
    exp_q.delete();
    mdl_q.delete();
    m_pkt = 0;
    @(negedge clk);
    resetn = 1'b1;
    step(0, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_fifo_pkt.md
Name: router_fifo_pkt

Overview:
Parametrised, packet-aware FIFO buffering one output channel of the router. Generalises the fixed 16x8 router FIFO in both width and depth. Each entry carries a header marker alongside its data, so the read side tracks packet boundaries from the header length field and flags packet completion. Sits between the router's register/sync stage and each output port; one instance per destination channel.

Parameters:
DATA_WIDTH, 8, data bits per entry; minimum 4; header length field is datain[DATA_WIDTH-1:2]
DEPTH, 16, number of entries; power of 2, minimum 4
AF_LEVEL, DEPTH-2, almost_full asserted when occupancy >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when occupancy <= AE_LEVEL

Ports:
clk  input  1  clock, all state on rising edge
resetn  input  1  asynchronous active-low reset
soft_reset  input  1  synchronous flush, active high
write_enb  input  1  write request
read_enb  input  1  read request
lfd_state  input  1  marks current datain as packet header
datain  input  DATA_WIDTH  write data
dataout  output  DATA_WIDTH  registered read data
full  output  1  occupancy == DEPTH
empty  output  1  occupancy == 0
almost_full  output  1  occupancy >= AF_LEVEL
almost_empty  output  1  occupancy <= AE_LEVEL
fifo_count  output  $clog2(DEPTH)+1  current occupancy
pkt_busy  output  1  read side is inside a packet (pkt_cnt != 0)
pkt_done  output  1  one-cycle pulse: final byte (parity) of a packet was read
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Storage: DEPTH entries of DATA_WIDTH+1 bits, {lfd_state, datain}. Write and read pointers wrap modulo DEPTH.
- Write accepted iff write_enb && !full, with full sampled at start of cycle. A write while full is dropped, even if a read is accepted in the same cycle.
- Read accepted iff read_enb && !empty.
- Read latency: 1 cycle. On an accepted read, dataout <= entry data at the next edge. Otherwise dataout holds.
- Simultaneous accepted read and write: count unchanged, both pointers advance, order preserved.
- Flags and fifo_count derive combinationally from a registered occupancy counter.
- Packet tracking, on each accepted read:
  - Entry lfd=1: pkt_cnt <= header[DATA_WIDTH-1:2] + 1, covering payload plus parity.
  - Entry lfd=0 with pkt_cnt != 0: pkt_cnt decrements.
  - pkt_done pulses high the cycle after the read that takes pkt_cnt from 1 to 0. This is the same cycle the parity byte appears on dataout.
  - Payload length 0: pkt_cnt loads 1, so the next read completes the packet.
  - Header read while pkt_cnt != 0 (truncated packet): pkt_cnt reloads, no pkt_done.
  - Non-header read while pkt_cnt == 0: data passes, counters unchanged.
- pkt_cnt width is DATA_WIDTH-1 bits, so length+1 never overflows.
- soft_reset, synchronous: clears pointers, count, pkt_cnt, dataout, pkt_done, overflow and underflow. It has priority over a same-cycle read or write, and memory contents are not cleared.
- resetn low, asynchronous: same clears as soft_reset, independent of clk.
- Reset values: dataout=0, full=0, empty=1, almost_full=0, almost_empty=1, fifo_count=0, pkt_busy=0, pkt_done=0, overflow=0, underflow=0.

Optional Feature:
ROUTER_FIFO_ERR_EN
- Defined:
  - overflow sets on any cycle with write_enb && full.
  - underflow sets on any cycle with read_enb && empty.
  - Both are sticky until resetn or soft_reset.
- Undefined: overflow and underflow ports remain present but are tied to 0, and no error logic is synthesised.

Test Plan:
1. Defaults. Reset, then write header 8'h39 (len 14, addr 01) with lfd=1, 14 random payload bytes, then parity -> almost_full=1 at count 14; full=1 and fifo_count=16 after the 16th write.
2. Full, write_enb=1, one more write of 8'hAA -> count stays 16, data dropped; overflow=1 with macro, 0 without.
3. Read 16 consecutive cycles ->
   - dataout matches the written sequence one cycle after each read.
   - pkt_busy=1 from the cycle after the header read.
   - pkt_done pulses once, together with the parity on dataout.
   - empty=1 at the end.
   - One extra read sets underflow (macro) with dataout unchanged.
4. At count 5, read and write simultaneously for 4 cycles -> fifo_count stays 5 and FIFO order is preserved.
5. Write 7 entries, read header plus 2 bytes, assert soft_reset with write_enb=1 -> count=0, empty=1, dataout=0, pkt_busy=0, error flags clear. A subsequent write of 8'h55 then read returns 8'h55.
6. Wrap and zero-length packet:
   - Write 10, read 10, write 12 -> read data correct across the pointer wrap.
   - Header 8'h01 (len 0) then parity, read 2 -> pkt_done after the 2nd read.
   - Assert resetn low mid-read -> outputs return to reset values immediately.
